// File: rtl/btb_pkg.sv
// Shared definitions for the set-associative branch target buffer.
//   cnt_t           : 2-bit saturating direction counter
//   CNT_WEAK_TAKEN  : counter value given to a freshly allocated entry
//   CNT_MAX         : counter saturation value
//   state_t         : invalidation sequencer states
//   pc_index/pc_tag : split a fetch PC into set index and tag
package btb_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_WEAK_TAKEN = 2'd2;
    localparam cnt_t CNT_MAX        = 2'd3;
    localparam cnt_t CNT_MIN        = 2'd0;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    // Set index is pc[set_bits+1:2]; caller narrows the result to its index width.
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned set_bits);
        return (pc >> 2) & ((32'd1 << set_bits) - 32'd1);
    endfunction

    // Tag is pc[31:set_bits+2]; caller narrows the result to its tag width.
    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned set_bits);
        return pc >> (set_bits + 2);
    endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the BTB: valid/tag/target/counter storage for every set.
//   clk_i, rst_i          : clock, async active-low reset (read-port valid flag only)
//   rd_en, rd_idx         : registered lookup read; rd_* valid the cycle after rd_en
//   rd_valid/tag/target   : registered read data
//   rd_taken              : registered counter MSB
//   pr_idx, pr_*          : combinational probe used by the update path
//   wr_en, wr_idx, wr_*   : single write port; sets valid, writes tag/counter,
//                           target only when wr_target_en
//   clr_en, clr_idx       : clears the valid bit of one set
module btb_way
    import btb_pkg::*;
#(
    parameter int unsigned SET_BITS = 6,
    parameter int unsigned TAG_W    = 30 - SET_BITS
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                rd_en,
    input  logic [SET_BITS-1:0] rd_idx,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [31:0]         rd_target,
    output logic                rd_taken,
    input  logic [SET_BITS-1:0] pr_idx,
    output logic                pr_valid,
    output logic [TAG_W-1:0]    pr_tag,
    output cnt_t                pr_cnt,
    input  logic                wr_en,
    input  logic [SET_BITS-1:0] wr_idx,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic                wr_target_en,
    input  logic [31:0]         wr_target,
    input  cnt_t                wr_cnt,
    input  logic                clr_en,
    input  logic [SET_BITS-1:0] clr_idx
);

    localparam int unsigned SETS = 1 << SET_BITS;

    logic              valid_mem  [SETS];
    logic [TAG_W-1:0]  tag_mem    [SETS];
    logic [31:0]       target_mem [SETS];
    cnt_t              cnt_mem    [SETS];

    // Valid bits are not reset; the top-level walk clears them set by set.
    always_ff @(posedge clk_i) begin
        if (clr_en) begin
            valid_mem[clr_idx] <= 1'b0;
        end else if (wr_en) begin
            valid_mem[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
            cnt_mem[wr_idx] <= wr_cnt;
            if (wr_target_en) begin
                target_mem[wr_idx] <= wr_target;
            end
        end
    end

    // Nonblocking capture gives read-before-write against a same-edge update.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_valid <= valid_mem[rd_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rd_en) begin
            rd_tag    <= tag_mem[rd_idx];
            rd_target <= target_mem[rd_idx];
            rd_taken  <= cnt_mem[rd_idx][1];
        end
    end

    assign pr_valid = valid_mem[pr_idx];
    assign pr_tag   = tag_mem[pr_idx];
    assign pr_cnt   = cnt_mem[pr_idx];

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with 2-bit direction counters.
//   clk_i, rst_i            : clock, async active-low reset
//   flush_i                 : invalidate whole BTB (restarts the invalidation walk)
//   lookup_valid_i/pc_i     : lookup request; response one cycle later
//   resp_valid_o            : response valid
//   hit_o, taken_o, target_o: hit, predicted direction, predicted target (0 on miss)
//   upd_valid_i, upd_pc_i,
//   upd_taken_i, upd_target_i : resolved-branch update (ignored while busy or flushing)
//   busy_o                  : invalidation walk in progress
module btb_assoc
    import btb_pkg::*;
#(
    parameter int unsigned SET_BITS = 6,
    parameter int unsigned WAYS     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        lookup_valid_i,
    input  logic [31:0] lookup_pc_i,
    output logic        resp_valid_o,
    output logic        hit_o,
    output logic        taken_o,
    output logic [31:0] target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    output logic        busy_o
);

    localparam int unsigned SETS  = 1 << SET_BITS;
    localparam int unsigned TAG_W = 30 - SET_BITS;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef logic [SET_BITS-1:0] idx_t;
    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [WAY_W-1:0]    way_t;

    // ------------------------------------------------------------------
    // Invalidation sequencer
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    idx_t   walk_q, walk_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= INIT;
            walk_q  <= '0;
        end else begin
            state_q <= state_d;
            walk_q  <= walk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        walk_d  = walk_q;
        if (flush_i) begin
            state_d = INIT;
            walk_d  = '0;
        end else if (state_q == INIT) begin
            walk_d = walk_q + idx_t'(1);
            if (walk_q == '1) begin
                state_d = READY;
            end
        end
    end

    assign busy_o = (state_q == INIT);

    // ------------------------------------------------------------------
    // Address split
    // ------------------------------------------------------------------
    idx_t look_idx, upd_idx;
    tag_t look_tag, upd_tag;

    assign look_idx = idx_t'(pc_index(lookup_pc_i, SET_BITS));
    assign look_tag = tag_t'(pc_tag(lookup_pc_i, SET_BITS));
    assign upd_idx  = idx_t'(pc_index(upd_pc_i, SET_BITS));
    assign upd_tag  = tag_t'(pc_tag(upd_pc_i, SET_BITS));

    // ------------------------------------------------------------------
    // Way storage
    // ------------------------------------------------------------------
    logic [WAYS-1:0] rd_valid, rd_taken, pr_valid, wr_en;
    tag_t            rd_tag  [WAYS];
    logic [31:0]     rd_target [WAYS];
    tag_t            pr_tag  [WAYS];
    cnt_t            pr_cnt  [WAYS];
    logic            wr_target_en;
    cnt_t            wr_cnt;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        btb_way #(
            .SET_BITS (SET_BITS),
            .TAG_W    (TAG_W)
        ) u_way (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .rd_en        (lookup_valid_i),
            .rd_idx       (look_idx),
            .rd_valid     (rd_valid[g]),
            .rd_tag       (rd_tag[g]),
            .rd_target    (rd_target[g]),
            .rd_taken     (rd_taken[g]),
            .pr_idx       (upd_idx),
            .pr_valid     (pr_valid[g]),
            .pr_tag       (pr_tag[g]),
            .pr_cnt       (pr_cnt[g]),
            .wr_en        (wr_en[g]),
            .wr_idx       (upd_idx),
            .wr_tag       (upd_tag),
            .wr_target_en (wr_target_en),
            .wr_target    (upd_target_i),
            .wr_cnt       (wr_cnt),
            .clr_en       (busy_o),
            .clr_idx      (walk_q)
        );
    end

    // ------------------------------------------------------------------
    // Lookup response
    // ------------------------------------------------------------------
    logic            resp_q, live_q;
    tag_t            look_tag_q;
    logic [WAYS-1:0] look_hit_vec;
    logic            look_hit, look_taken;
    logic [31:0]     look_target;

    // live_q masks responses to lookups issued during the walk, whose
    // valid bits may not have been cleared yet.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            resp_q     <= 1'b0;
            live_q     <= 1'b0;
            look_tag_q <= '0;
        end else begin
            resp_q <= lookup_valid_i;
            live_q <= lookup_valid_i && (state_q == READY);
            if (lookup_valid_i) begin
                look_tag_q <= look_tag;
            end
        end
    end

    always_comb begin
        look_hit_vec = '0;
        look_taken   = 1'b0;
        look_target  = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            look_hit_vec[w] = rd_valid[w] && (rd_tag[w] == look_tag_q);
            if (look_hit_vec[w]) begin
                look_taken  = look_taken | rd_taken[w];
                look_target = look_target | rd_target[w];
            end
        end
        look_hit = |look_hit_vec;
    end

    assign resp_valid_o = resp_q;
    assign hit_o        = resp_q && live_q && look_hit;
    assign taken_o      = hit_o && look_taken;
    assign target_o     = hit_o ? look_target : '0;

    // ------------------------------------------------------------------
    // Update: hit detection, victim choice, counter update
    // ------------------------------------------------------------------
    logic            upd_ok, upd_hit, free_found, rr_adv;
    logic [WAYS-1:0] upd_hit_vec;
    way_t            hit_way, free_way, sel_way, rr_cur;
    cnt_t            cur_cnt;

    assign upd_ok = upd_valid_i && (state_q == READY) && !flush_i;

    always_comb begin
        upd_hit_vec  = '0;
        upd_hit      = 1'b0;
        hit_way      = '0;
        cur_cnt      = CNT_MIN;
        free_found   = 1'b0;
        free_way     = '0;
        sel_way      = '0;
        wr_en        = '0;
        wr_cnt       = CNT_WEAK_TAKEN;
        wr_target_en = 1'b0;
        rr_adv       = 1'b0;

        for (int unsigned w = 0; w < WAYS; w++) begin
            upd_hit_vec[w] = pr_valid[w] && (pr_tag[w] == upd_tag);
            if (upd_hit_vec[w]) begin
                upd_hit = 1'b1;
                hit_way = way_t'(w);
                cur_cnt = pr_cnt[w];
            end
            if (!pr_valid[w] && !free_found) begin
                free_found = 1'b1;
                free_way   = way_t'(w);
            end
        end

        if (upd_ok) begin
            if (upd_hit) begin
                sel_way      = hit_way;
                wr_target_en = upd_taken_i;
                if (upd_taken_i) begin
                    wr_cnt = (cur_cnt == CNT_MAX) ? CNT_MAX : cur_cnt + cnt_t'(1);
                end else begin
                    wr_cnt = (cur_cnt == CNT_MIN) ? CNT_MIN : cur_cnt - cnt_t'(1);
                end
            end else if (upd_taken_i) begin
                sel_way      = free_found ? free_way : rr_cur;
                wr_target_en = 1'b1;
                wr_cnt       = CNT_WEAK_TAKEN;
                rr_adv       = !free_found;
            end
            for (int unsigned w = 0; w < WAYS; w++) begin
                wr_en[w] = (upd_hit || upd_taken_i) && (sel_way == way_t'(w));
            end
        end
    end

    // Round-robin pointers only matter when there is a choice of victim.
    if (WAYS > 1) begin : g_rr
        way_t rr_q [SETS];

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    rr_q[s] <= '0;
                end
            end else if (rr_adv) begin
                rr_q[upd_idx] <= rr_q[upd_idx] + way_t'(1);
            end
        end

        assign rr_cur = rr_q[upd_idx];
    end else begin : g_no_rr
        assign rr_cur = '0;
    end

    // The allocation rule never places a tag twice in one set.
    a_look_onehot : assert property (@(posedge clk_i) disable iff (!rst_i)
        (resp_q && live_q) |-> $onehot0(look_hit_vec));
    a_upd_onehot : assert property (@(posedge clk_i) disable iff (!rst_i)
        (upd_valid_i && state_q == READY) |-> $onehot0(upd_hit_vec));

endmodule

// File: tb/tb_btb_assoc.sv
module tb_btb_assoc;

    localparam int SET_BITS = 6;
    localparam int WAYS     = 2;
    localparam int SETS     = 1 << SET_BITS;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        lookup_valid_i;
    logic [31:0] lookup_pc_i;
    logic        resp_valid_o;
    logic        hit_o;
    logic        taken_o;
    logic [31:0] target_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        busy_o;

    btb_assoc #(
        .SET_BITS (SET_BITS),
        .WAYS     (WAYS)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .lookup_valid_i (lookup_valid_i),
        .lookup_pc_i    (lookup_pc_i),
        .resp_valid_o   (resp_valid_o),
        .hit_o          (hit_o),
        .taken_o        (taken_o),
        .target_o       (target_o),
        .upd_valid_i    (upd_valid_i),
        .upd_pc_i       (upd_pc_i),
        .upd_taken_i    (upd_taken_i),
        .upd_target_i   (upd_target_i),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks;
    int n_fail;

    // Reference model: per set, a list of WAYS entries plus a victim pointer.
    bit [WAYS-1:0] m_valid  [SETS];
    logic [31:0]   m_tag    [SETS][WAYS];
    logic [31:0]   m_target [SETS][WAYS];
    int            m_cnt    [SETS][WAYS];
    int            m_rr     [SETS];
    int            m_remaining;

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) m_valid[s] = '0;
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output bit h, output bit tk,
                                         output logic [31:0] tgt);
        int s;
        logic [31:0] t;
        s = int'((pc >> 2) % SETS);
        t = pc >> (SET_BITS + 2);
        h = 0; tk = 0; tgt = 0;
        if (m_remaining > 0) return;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                h = 1; tk = (m_cnt[s][w] >= 2); tgt = m_target[s][w];
            end
        end
    endfunction

    function automatic void model_update(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        int s, hw, v;
        logic [31:0] t;
        s = int'((pc >> 2) % SETS);
        t = pc >> (SET_BITS + 2);
        hw = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
        if (hw >= 0) begin
            if (taken) begin
                if (m_cnt[s][hw] < 3) m_cnt[s][hw]++;
                m_target[s][hw] = tgt;
            end else if (m_cnt[s][hw] > 0) begin
                m_cnt[s][hw]--;
            end
        end else if (taken) begin
            v = -1;
            for (int w = 0; w < WAYS; w++)
                if (!m_valid[s][w] && v < 0) v = w;
            if (v < 0) begin
                v = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % WAYS;
            end
            m_valid[s][v]  = 1'b1;
            m_tag[s][v]    = t;
            m_target[s][v] = tgt;
            m_cnt[s][v]    = 2;
        end
    endfunction

    // One clock: drive inputs, advance the model at the edge, check #1 later.
    task automatic do_cycle(input bit lv, input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                            input bit ut, input logic [31:0] utgt, input bit fl,
                            output bit r_hit, output bit r_taken, output logic [31:0] r_tgt);
        bit          eh, et;
        logic [31:0] eg;
        lookup_valid_i = lv; lookup_pc_i = lpc;
        upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut; upd_target_i = utgt;
        flush_i = fl;
        model_lookup(lpc, eh, et, eg);
        @(posedge clk_i);
        if (fl) begin
            m_remaining = SETS;
            model_clear();
        end else if (m_remaining > 0) begin
            m_remaining--;
        end else if (uv) begin
            model_update(upc, ut, utgt);
        end
        #1;
        lookup_valid_i = 0; upd_valid_i = 0; flush_i = 0;
        r_hit = hit_o; r_taken = taken_o; r_tgt = target_o;
        n_checks++;
        if (resp_valid_o !== lv) begin
            $display("FAIL resp_valid pc=%h got=%b exp=%b", lpc, resp_valid_o, lv); n_fail++;
        end
        n_checks++;
        if (busy_o !== (m_remaining > 0)) begin
            $display("FAIL busy got=%b exp=%b", busy_o, m_remaining > 0); n_fail++;
        end
        if (lv) begin
            n_checks++;
            if (hit_o !== eh) begin
                $display("FAIL hit pc=%h got=%b exp=%b", lpc, hit_o, eh); n_fail++;
            end
            n_checks++;
            if (taken_o !== et) begin
                $display("FAIL taken pc=%h got=%b exp=%b", lpc, taken_o, et); n_fail++;
            end
            n_checks++;
            if (target_o !== eg) begin
                $display("FAIL target pc=%h got=%h exp=%h", lpc, target_o, eg); n_fail++;
            end
        end
    endtask

    task automatic idle(input int n);
        bit h, t; logic [31:0] g;
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, h, t, g);
    endtask

    task automatic test_reset();
        bit h, t; logic [31:0] g;
        int busy_count;
        rst_i = 0; flush_i = 0; lookup_valid_i = 0; lookup_pc_i = 0;
        upd_valid_i = 0; upd_pc_i = 0; upd_taken_i = 0; upd_target_i = 0;
        for (int s = 0; s < SETS; s++) m_rr[s] = 0;
        model_clear();
        #2;
        n_checks++;
        if (resp_valid_o !== 1'b0 || hit_o !== 1'b0 || taken_o !== 1'b0 || target_o !== 32'h0 || busy_o !== 1'b1) begin
            $display("FAIL reset_state got rv=%b hit=%b tk=%b tgt=%h busy=%b exp 0/0/0/0/1",
                     resp_valid_o, hit_o, taken_o, target_o, busy_o);
            n_fail++;
        end
        @(posedge clk_i); #1;
        rst_i = 1;
        m_remaining = SETS;
        busy_count = (busy_o === 1'b1) ? 1 : 0;
        do_cycle(1, 32'h100, 0, 0, 0, 0, 0, h, t, g);
        n_checks++;
        if (resp_valid_o !== 1'b1 || h !== 1'b0) begin
            $display("FAIL lookup_in_walk got rv=%b hit=%b exp rv=1 hit=0", resp_valid_o, h); n_fail++;
        end
        if (busy_o === 1'b1) busy_count++;
        for (int i = 0; i < SETS; i++) begin
            idle(1);
            if (busy_o === 1'b1) busy_count++;
        end
        n_checks++;
        if (busy_count != SETS) begin
            $display("FAIL busy_length got=%0d exp=%0d", busy_count, SETS); n_fail++;
        end
    endtask

    task automatic test_hit_counter();
        bit h, t; logic [31:0] g;
        do_cycle(0, 0, 1, 32'h0000_1004, 1, 32'h2000, 0, h, t, g);
        do_cycle(1, 32'h0000_1004, 0, 0, 0, 0, 0, h, t, g);
        n_checks++;
        if (h !== 1'b1 || t !== 1'b1 || g !== 32'h2000) begin
            $display("FAIL alloc_hit got hit=%b tk=%b tgt=%h exp 1/1/00002000", h, t, g); n_fail++;
        end
        do_cycle(0, 0, 1, 32'h0000_1004, 0, 32'hdead_0000, 0, h, t, g);
        do_cycle(0, 0, 1, 32'h0000_1004, 0, 32'hdead_0000, 0, h, t, g);
        do_cycle(1, 32'h0000_1004, 0, 0, 0, 0, 0, h, t, g);
        n_checks++;
        if (h !== 1'b1 || t !== 1'b0 || g !== 32'h2000) begin
            $display("FAIL not_taken_hit got hit=%b tk=%b tgt=%h exp 1/0/00002000", h, t, g); n_fail++;
        end
    endtask

    task automatic test_saturation();
        bit h, t; logic [31:0] g;
        for (int i = 0; i < 5; i++) do_cycle(0, 0, 1, 32'h0000_1004, 1, 32'h2000, 0, h, t, g);
        do_cycle(0, 0, 1, 32'h0000_1004, 0, 32'h0, 0, h, t, g);
        do_cycle(1, 32'h0000_1004, 0, 0, 0, 0, 0, h, t, g);
        n_checks++;
        if (h !== 1'b1 || t !== 1'b1) begin
            $display("FAIL saturation got hit=%b tk=%b exp 1/1", h, t); n_fail++;
        end
    endtask

    task automatic test_eviction();
        bit h, t; logic [31:0] g;
        do_cycle(0, 0, 1, 32'h0000_2004, 1, 32'h2200, 0, h, t, g);
        do_cycle(0, 0, 1, 32'h0000_3004, 1, 32'h3300, 0, h, t, g);
        do_cycle(1, 32'h0000_1004, 0, 0, 0, 0, 0, h, t, g);
        n_checks++;
        if (h !== 1'b0) begin $display("FAIL evict_1004 got hit=%b exp 0", h); n_fail++; end
        do_cycle(1, 32'h0000_2004, 0, 0, 0, 0, 0, h, t, g);
        n_checks++;
        if (h !== 1'b1 || g !== 32'h2200) begin
            $display("FAIL keep_2004 got hit=%b tgt=%h exp 1/00002200", h, g); n_fail++;
        end
        do_cycle(0, 0, 1, 32'h0000_4004, 1, 32'h4400, 0, h, t, g);
        do_cycle(1, 32'h0000_2004, 0, 0, 0, 0, 0, h, t, g);
        n_checks++;
        if (h !== 1'b0) begin $display("FAIL evict_2004 got hit=%b exp 0", h); n_fail++; end
        do_cycle(1, 32'h0000_3004, 0, 0, 0, 0, 0, h, t, g);
        n_checks++;
        if (h !== 1'b1 || g !== 32'h3300) begin
            $display("FAIL keep_3004 got hit=%b tgt=%h exp 1/00003300", h, g); n_fail++;
        end
        do_cycle(1, 32'h0000_4004, 0, 0, 0, 0, 0, h, t, g);
        n_checks++;
        if (h !== 1'b1 || g !== 32'h4400) begin
            $display("FAIL new_4004 got hit=%b tgt=%h exp 1/00004400", h, g); n_fail++;
        end
    endtask

    task automatic test_same_cycle();
        bit h, t; logic [31:0] g;
        do_cycle(1, 32'h0000_5008, 1, 32'h0000_5008, 1, 32'h6000, 0, h, t, g);
        n_checks++;
        if (h !== 1'b0) begin $display("FAIL read_before_write got hit=%b exp 0", h); n_fail++; end
        do_cycle(1, 32'h0000_5008, 0, 0, 0, 0, 0, h, t, g);
        n_checks++;
        if (h !== 1'b1 || g !== 32'h6000) begin
            $display("FAIL after_write got hit=%b tgt=%h exp 1/00006000", h, g); n_fail++;
        end
    endtask

    task automatic test_flush();
        bit h, t; logic [31:0] g;
        logic [31:0] pcs [7];
        pcs = '{32'h1004, 32'h2004, 32'h3004, 32'h4004, 32'h5008, 32'h7004, 32'h700c};
        do_cycle(0, 0, 1, 32'h0000_7004, 1, 32'h7777, 1, h, t, g);
        for (int i = 0; i < SETS; i++) begin
            if (i == 10) do_cycle(0, 0, 1, 32'h0000_700c, 1, 32'h7788, 0, h, t, g);
            else         idle(1);
        end
        n_checks++;
        if (busy_o !== 1'b0) begin $display("FAIL flush_done got busy=%b exp 0", busy_o); n_fail++; end
        foreach (pcs[i]) begin
            do_cycle(1, pcs[i], 0, 0, 0, 0, 0, h, t, g);
            n_checks++;
            if (h !== 1'b0) begin $display("FAIL flushed_miss pc=%h got hit=%b exp 0", pcs[i], h); n_fail++; end
        end
    endtask

    task automatic test_random();
        bit h, t; logic [31:0] g;
        bit lv, uv, ut, fl;
        logic [31:0] lpc, upc, tgt;
        for (int i = 0; i < 3000; i++) begin
            lv  = ($urandom_range(0, 3) != 0);
            uv  = ($urandom_range(0, 1) != 0);
            ut  = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 199) == 0);
            lpc = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 2);
            upc = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 2);
            tgt = $urandom;
            do_cycle(lv, lpc, uv, upc, ut, tgt, fl, h, t, g);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_hit_counter();
        test_saturation();
        test_eviction();
        test_same_cycle();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
